// File: rtl/bus_arbiter_rr.sv
// Two-core round-robin bus arbiter with bounded hold time and a dead TURN cycle between owners.
// Memory-side address, data and rw follow the granted core combinationally and are zero when the bus is idle.
module bus_arbiter_rr #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       core0_request,
  input  logic       core1_request,
  output logic       core0_grant,
  output logic       core1_grant,
  input  logic [8:0] core0_address,
  input  logic [8:0] core1_address,
  input  logic       core0_rw,
  input  logic       core1_rw,
  input  logic [7:0] core0_data_in,
  input  logic [7:0] core1_data_in,
  output logic [7:0] core0_data_out,
  output logic [7:0] core1_data_out,
  output logic [8:0] RAM_address,
  output logic [7:0] RAM_data_in,
  input  logic [7:0] RAM_data_out,
  output logic       rw
);

  localparam int unsigned HOLD_W = 8;
  localparam logic [HOLD_W-1:0] MAX_HOLD_C = HOLD_W'(MAX_HOLD);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, TURN} state_t;

  state_t            r_state;
  logic              r_last_owner;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic              r_grant0;
  logic              r_grant1;

  logic w_pick0;
  logic w_pick1;
  logic w_hold_max;

  // On contention the core that did not own the bus last wins.
  assign w_pick0    = core0_request & (~core1_request | r_last_owner);
  assign w_pick1    = core1_request & (~core0_request | ~r_last_owner);
  assign w_hold_max = (r_hold_cnt == MAX_HOLD_C);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_last_owner <= 1'b0;
      r_hold_cnt   <= '0;
      r_grant0     <= 1'b0;
      r_grant1     <= 1'b0;
    end else begin
      case (r_state)
        IDLE, TURN: begin
          if (w_pick0) begin
            r_state      <= GRANT0;
            r_last_owner <= 1'b0;
            r_hold_cnt   <= HOLD_W'(1);
            r_grant0     <= 1'b1;
            r_grant1     <= 1'b0;
          end else if (w_pick1) begin
            r_state      <= GRANT1;
            r_last_owner <= 1'b1;
            r_hold_cnt   <= HOLD_W'(1);
            r_grant0     <= 1'b0;
            r_grant1     <= 1'b1;
          end else begin
            r_state  <= IDLE;
            r_grant0 <= 1'b0;
            r_grant1 <= 1'b0;
          end
        end
        GRANT0: begin
          if (!core0_request || (w_hold_max && core1_request)) begin
            r_state  <= TURN;
            r_grant0 <= 1'b0;
          end else if (!w_hold_max) begin
            r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
          end
        end
        GRANT1: begin
          if (!core1_request || (w_hold_max && core0_request)) begin
            r_state  <= TURN;
            r_grant1 <= 1'b0;
          end else if (!w_hold_max) begin
            r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
          end
        end
        default: begin
          r_state  <= IDLE;
          r_grant0 <= 1'b0;
          r_grant1 <= 1'b0;
        end
      endcase
    end
  end

  assign core0_grant = r_grant0;
  assign core1_grant = r_grant1;

  // Bus mux: only the owner reaches memory; an idle bus drives zeros so no write can slip through.
  assign RAM_address = r_grant0 ? core0_address :
                       r_grant1 ? core1_address : 9'h000;
  assign RAM_data_in = r_grant0 ? core0_data_in :
                       r_grant1 ? core1_data_in : 8'h00;
  assign rw          = r_grant0 ? core0_rw :
                       r_grant1 ? core1_rw : 1'b0;

  assign core0_data_out = r_grant0 ? RAM_data_out : 8'h00;
  assign core1_data_out = r_grant1 ? RAM_data_out : 8'h00;

endmodule
